// File: rtl/rf_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// Module   : rf_writeback_arbiter
// Purpose  : Two-source (ALU / load) writeback arbiter owning the register
//            file write port; per-source FIFOs, round-robin issue, registered
//            write strobe. Optional macro RF_WB_R0_DISCARD_EN suppresses
//            writes to r0.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module rf_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_waddr,
  input  logic [DATA_W-1:0]          alu_wdata,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_W-1:0]          mem_waddr,
  input  logic [DATA_W-1:0]          mem_wdata,
  output logic                       write_en,
  output logic [ADDR_W-1:0]          waddr,
  output logic [DATA_W-1:0]          wdata,
  output logic [$clog2(DEPTH)+1:0]   pending,
  output logic                       busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = IDX_W + 2;
  localparam int ENT_W = ADDR_W + DATA_W;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;

  localparam logic PRIO_ALU = 1'b0;
  localparam logic PRIO_MEM = 1'b1;

  logic [1:0]       in_valid;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       empty;
  logic [1:0]       full;
  logic [ENT_W-1:0] in_entry [2];
  logic [ENT_W-1:0] head     [2];
  logic [PTR_W-1:0] count    [2];

  assign in_valid            = {mem_valid, alu_valid};
  assign in_entry[SRC_ALU]   = {alu_waddr, alu_wdata};
  assign in_entry[SRC_MEM]   = {mem_waddr, mem_wdata};
  assign push                = in_valid & ~full;

  genvar s;
  generate
    for (s = 0; s < 2; s++) begin : g_src
      logic [PTR_W-1:0] wptr_q;
      logic [PTR_W-1:0] rptr_q;
      logic [ENT_W-1:0] store_q [DEPTH];

      // Extra MSB on the pointers distinguishes full from empty on wrap.
      assign empty[s] = (wptr_q == rptr_q);
      assign full[s]  = ((wptr_q ^ rptr_q) == {1'b1, {(PTR_W-1){1'b0}}});
      assign count[s] = wptr_q - rptr_q;
      assign head[s]  = store_q[rptr_q[IDX_W-1:0]];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          wptr_q <= '0;
          rptr_q <= '0;
        end else if (flush) begin
          wptr_q <= '0;
          rptr_q <= '0;
        end else begin
          if (push[s]) wptr_q <= wptr_q + 1'b1;
          if (pop[s])  rptr_q <= rptr_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (push[s]) store_q[wptr_q[IDX_W-1:0]] <= in_entry[s];
      end
    end
  endgenerate

  assign alu_ready = ~full[SRC_ALU];
  assign mem_ready = ~full[SRC_MEM];

  logic              prio_q,  prio_d;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ENT_W-1:0]  sel_entry;
  logic              issue;

  always_comb begin
    pop    = 2'b00;
    prio_d = prio_q;
    if (!flush) begin
      if (!empty[SRC_ALU] && !empty[SRC_MEM]) begin
        if (prio_q == PRIO_MEM) pop[SRC_MEM] = 1'b1;
        else                    pop[SRC_ALU] = 1'b1;
        prio_d = ~prio_q;
      end else if (!empty[SRC_ALU]) begin
        pop[SRC_ALU] = 1'b1;
      end else if (!empty[SRC_MEM]) begin
        pop[SRC_MEM] = 1'b1;
      end
    end
  end

  assign sel_entry = pop[SRC_MEM] ? head[SRC_MEM] : head[SRC_ALU];

`ifdef RF_WB_R0_DISCARD_EN
  // r0 entries are consumed (pointer and count still move) but never written.
  assign issue = (|pop) && (sel_entry[ENT_W-1:DATA_W] != '0);
`else
  assign issue = |pop;
`endif

  always_comb begin
    we_d    = issue;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (issue) begin
      waddr_d = sel_entry[ENT_W-1:DATA_W];
      wdata_d = sel_entry[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q  <= PRIO_MEM;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      prio_q  <= prio_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign write_en = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign pending  = CNT_W'(count[SRC_ALU]) + CNT_W'(count[SRC_MEM]);
  assign busy     = (pending != '0) || we_q;

  logic unused_prio;
  assign unused_prio = PRIO_ALU;

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// Module   : tb_rf_writeback_arbiter
// Purpose  : Directed, table-driven checks of rf_writeback_arbiter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rf_writeback_arbiter;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        write_en;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  pending;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [16];

  rf_writeback_arbiter #(.DATA_W(32), .ADDR_W(4), .DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_waddr (alu_waddr),
    .alu_wdata (alu_wdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .write_en  (write_en),
    .waddr     (waddr),
    .wdata     (wdata),
    .pending   (pending),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model fed only by the write port.
  always @(posedge clk) begin
    if (write_en) rf[waddr] <= wdata;
  end

  typedef struct {
    logic        av;
    logic [3:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [3:0]  ma;
    logic [31:0] md;
    logic        fl;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    int          pend;
    logic        ardy;
    logic        mrdy;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                     input logic mv, input logic [3:0] ma, input logic [31:0] md,
                     input logic fl, input logic we, input logic [3:0] wa,
                     input logic [31:0] wd, input int pend,
                     input logic ardy, input logic mrdy);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
    v.fl = fl; v.we = we; v.wa = wa; v.wd = wd; v.pend = pend;
    v.ardy = ardy; v.mrdy = mrdy;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [3:0] ma, input logic [31:0] md,
                       input logic fl);
    alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    mem_valid = mv; mem_waddr = ma; mem_wdata = md;
    flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    drive(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;

    // ---------------- reset default ----------------
    #50;
    chk("rst_we",   32'(write_en),  32'h0);
    chk("rst_pend", 32'(pending),   32'h0);
    chk("rst_ardy", 32'(alu_ready), 32'h1);
    chk("rst_mrdy", 32'(mem_ready), 32'h1);
    chk("rst_busy", 32'(busy),      32'h0);
    #50;
    reset_n = 1'b1;
    step();
    chk("rel_we",    32'(write_en), 32'h0);
    chk("rel_waddr", 32'(waddr),    32'h0);
    chk("rel_wdata", wdata,         32'h0);
    chk("rel_pend",  32'(pending),  32'h0);
    chk("rel_busy",  32'(busy),     32'h0);

    // ---------------- vector table ----------------
    // single ALU write
    add(1, 3, 32'hDEADBEEF, 0, 0, 0, 0,  0, 0, 32'h0,        1, 1, 1);
    add(0, 0, 0,            0, 0, 0, 0,  1, 3, 32'hDEADBEEF, 0, 1, 1);
    add(0, 0, 0,            0, 0, 0, 0,  0, 3, 32'hDEADBEEF, 0, 1, 1);
    // contention: MEM first after reset, then alternation
    add(1, 5, 32'h11, 1, 6, 32'h22, 0,   0, 3, 32'hDEADBEEF, 2, 1, 1);
    add(1, 7, 32'h33, 0, 0, 0,      0,   1, 6, 32'h22,       2, 1, 1);
    add(0, 0, 0,      0, 0, 0,      0,   1, 5, 32'h11,       1, 1, 1);
    add(0, 0, 0,      0, 0, 0,      0,   1, 7, 32'h33,       0, 1, 1);
    add(0, 0, 0,      0, 0, 0,      0,   0, 7, 32'h33,       0, 1, 1);
    // contention with pointer now at ALU
    add(1, 1, 32'hA1, 1, 2, 32'hB1, 0,   0, 7, 32'h33,       2, 1, 1);
    add(1, 8, 32'hA2, 1, 9, 32'hB2, 0,   1, 1, 32'hA1,       3, 1, 1);
    add(0, 0, 0,      0, 0, 0,      0,   1, 2, 32'hB1,       2, 1, 1);
    add(0, 0, 0,      0, 0, 0,      0,   1, 8, 32'hA2,       1, 1, 1);
    add(0, 0, 0,      0, 0, 0,      0,   1, 9, 32'hB2,       0, 1, 1);
    add(0, 0, 0,      0, 0, 0,      0,   0, 9, 32'hB2,       0, 1, 1);
    // back-pressure: both sources streaming, FIFOs fill
    add(1, 1, 32'hA0000000, 1, 8,  32'hB0000000, 0, 0, 9,  32'hB2,       2, 1, 1);
    add(1, 2, 32'hA0000001, 1, 9,  32'hB0000001, 0, 1, 8,  32'hB0000000, 3, 1, 1);
    add(1, 3, 32'hA0000002, 1, 10, 32'hB0000002, 0, 1, 1,  32'hA0000000, 4, 1, 1);
    add(1, 4, 32'hA0000003, 1, 11, 32'hB0000003, 0, 1, 9,  32'hB0000001, 5, 1, 1);
    add(1, 5, 32'hA0000004, 1, 12, 32'hB0000004, 0, 1, 2,  32'hA0000001, 6, 1, 1);
    add(1, 6, 32'hA0000005, 1, 13, 32'hB0000005, 0, 1, 10, 32'hB0000002, 7, 0, 1);
    add(1, 15, 32'hBAD0BAD0, 1, 14, 32'hB0000006, 0, 1, 3, 32'hA0000002, 7, 1, 0);
    add(1, 7, 32'hA0000006, 1, 15, 32'hBAD1BAD1, 0, 1, 11, 32'hB0000003, 7, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 4,  32'hA0000003, 6, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 12, 32'hB0000004, 5, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 5,  32'hA0000004, 4, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 13, 32'hB0000005, 3, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 6,  32'hA0000005, 2, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 14, 32'hB0000006, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 7,  32'hA0000006, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 7,  32'hA0000006, 0, 1, 1);
    // flush with entries queued; pointer (ALU) must survive the flush
    add(1, 10, 32'hF1, 1, 11, 32'hE1, 0, 0, 7,  32'hA0000006, 2, 1, 1);
    add(1, 10, 32'hF2, 1, 11, 32'hE2, 0, 1, 10, 32'hF1,       3, 1, 1);
    add(1, 10, 32'hF3, 0, 0,  0,      0, 1, 11, 32'hE1,       3, 1, 1);
    add(1, 10, 32'hF4, 0, 0,  0,      1, 0, 11, 32'hE1,       0, 1, 1);
    add(1, 12, 32'hC1, 1, 13, 32'hD1, 0, 0, 11, 32'hE1,       2, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 12, 32'hC1, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 13, 32'hD1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 13, 32'hD1, 0, 1, 1);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].av, vt[i].aa, vt[i].ad, vt[i].mv, vt[i].ma, vt[i].md, vt[i].fl);
      step();
      chk($sformatf("v%0d_we", i),    32'(write_en),  32'(vt[i].we));
      chk($sformatf("v%0d_waddr", i), 32'(waddr),     32'(vt[i].wa));
      chk($sformatf("v%0d_wdata", i), wdata,          vt[i].wd);
      chk($sformatf("v%0d_pend", i),  32'(pending),   32'(vt[i].pend));
      chk($sformatf("v%0d_ardy", i),  32'(alu_ready), 32'(vt[i].ardy));
      chk($sformatf("v%0d_mrdy", i),  32'(mem_ready), 32'(vt[i].mrdy));
      chk($sformatf("v%0d_busy", i),  32'(busy),
          32'((vt[i].pend != 0) || vt[i].we));
      if (i == 2) chk("rf3", rf[3], 32'hDEADBEEF);
    end

    // ---------------- asynchronous reset mid-operation ----------------
    drive(1, 2, 32'h5555, 1, 3, 32'h6666, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("pre_arst_we", 32'(write_en), 32'h1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_we",    32'(write_en),  32'h0);
    chk("arst_waddr", 32'(waddr),     32'h0);
    chk("arst_wdata", wdata,          32'h0);
    chk("arst_pend",  32'(pending),   32'h0);
    chk("arst_ardy",  32'(alu_ready), 32'h1);
    chk("arst_busy",  32'(busy),      32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("post_arst_we",   32'(write_en), 32'h0);
    chk("post_arst_pend", 32'(pending),  32'h0);

    // ---------------- r0 handling ----------------
    drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    step();
    chk("r0_pend1", 32'(pending), 32'h1);
    drive(1, 1, 32'h00001234, 0, 0, 0, 0);
    step();
    chk("r0_pend2", 32'(pending), 32'h1);
`ifdef RF_WB_R0_DISCARD_EN
    chk("r0_we", 32'(write_en), 32'h0);
`else
    chk("r0_we",    32'(write_en), 32'h1);
    chk("r0_waddr", 32'(waddr),    32'h0);
    chk("r0_wdata", wdata,         32'hFFFFFFFF);
`endif
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("r1_we",    32'(write_en), 32'h1);
    chk("r1_waddr", 32'(waddr),    32'h1);
    chk("r1_wdata", wdata,         32'h00001234);
    chk("r1_pend",  32'(pending),  32'h0);
    step();
    chk("r1_done_we", 32'(write_en), 32'h0);
    chk("rf1", rf[1], 32'h00001234);
`ifdef RF_WB_R0_DISCARD_EN
    chk("rf0", rf[0], 32'h0);
`else
    chk("rf0", rf[0], 32'hFFFFFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
